// File: rtl/ring_sample_ram_pkg.sv
// Sizing helpers and channel-slicing macro for the multi-channel sample ring.
// Default geometry matches the X/Y/Z accelerometer path.
`ifndef RING_SAMPLE_RAM_PKG_SV
`define RING_SAMPLE_RAM_PKG_SV

`define RSR_CH(vec, c, w) vec[(c)*(w) +: (w)]

package ring_sample_ram_pkg;

    localparam int NBITS_DEF = 12;
    localparam int NADDR_DEF = 3;
    localparam int NCHAN_DEF = 3;

    function automatic int depth(input int naddr);
        return 1 << naddr;
    endfunction

    function automatic int sumw(input int nbits, input int naddr);
        return nbits + naddr;
    endfunction

    function automatic int chanw(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

    localparam int D    = depth(NADDR_DEF);
    localparam int SUMW = sumw(NBITS_DEF, NADDR_DEF);

endpackage

`endif

// File: rtl/ring_sample_ram_if.sv
// Write/read/status bundle between the sensor front end and the sample ring.
interface ring_sample_ram_if #(
    parameter int NBits = 12,
    parameter int NAddr = 3,
    parameter int NChan = 3
);
    import ring_sample_ram_pkg::*;

    localparam int CW = chanw(NChan);
    localparam int SW = sumw(NBits, NAddr);

    logic                   clear;
    logic                   wr_en;
    logic [NChan*NBits-1:0] Data_in;
    logic                   rd_req;
    logic [CW-1:0]          rd_chan;
    logic [NAddr-1:0]       rd_offset;
    logic [NBits-1:0]       Data_out;
    logic                   rd_valid;
    logic                   rd_err;
    logic [NAddr:0]         count;
    logic                   full;
    logic [NChan*SW-1:0]    sum_out;
    logic [NChan*NBits-1:0] avg_out;

    modport master (
        output clear, wr_en, Data_in, rd_req, rd_chan, rd_offset,
        input  Data_out, rd_valid, rd_err, count, full, sum_out, avg_out
    );

    modport slave (
        input  clear, wr_en, Data_in, rd_req, rd_chan, rd_offset,
        output Data_out, rd_valid, rd_err, count, full, sum_out, avg_out
    );

endinterface

// File: rtl/ring_channel.sv
// One channel of the ring: D-deep sample array plus its running sum.
module ring_channel
    import ring_sample_ram_pkg::*;
#(
    parameter int NBits = 12,
    parameter int NAddr = 3
) (
    input  logic                           clk,
    input  logic                           rst_a,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic                           full,
    input  logic [NAddr-1:0]               wp,
    input  logic [NAddr-1:0]               rd_idx,
    input  logic [NBits-1:0]               sample,
    output logic [NBits-1:0]               rd_data,
    output logic [sumw(NBits, NAddr)-1:0]  sum
);
    localparam int D    = depth(NAddr);
    localparam int SUMW = sumw(NBits, NAddr);

    logic [NBits-1:0]       mem [D];
    logic [NBits-1:0]       oldest;
    logic signed [SUMW-1:0] new_x;
    logic signed [SUMW-1:0] old_x;
    logic signed [SUMW-1:0] sum_q;

    assign oldest = mem[wp];
    assign new_x  = {{NAddr{sample[NBits-1]}}, sample};
    // Once full, the slot under wp is the sample being evicted
    assign old_x  = full ? {{NAddr{oldest[NBits-1]}}, oldest} : '0;

    always_ff @(posedge clk) begin
        if (wr_en && !clear) mem[wp] <= sample;
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a)      sum_q <= '0;
        else if (clear) sum_q <= '0;
        else if (wr_en) sum_q <= sum_q + new_x - old_x;
    end

    assign rd_data = mem[rd_idx];
    assign sum     = sum_q;

endmodule

// File: rtl/ring_sample_ram.sv
// Multi-channel circular sample store with age-indexed reads and running sums.
module ring_sample_ram
    import ring_sample_ram_pkg::*;
#(
    parameter int NBits = 12,
    parameter int NAddr = 3,
    parameter int NChan = 3
) (
    input logic               clk,
    input logic               rst_a,
    ring_sample_ram_if.slave  bus
);
    localparam int D    = depth(NAddr);
    localparam int SUMW = sumw(NBits, NAddr);
    localparam logic [NAddr:0] DCNT = (NAddr+1)'(D);

    logic [NAddr-1:0] wp;
    logic [NAddr-1:0] rd_idx;
    logic [NAddr:0]   cnt;
    logic             full;
    logic             do_wr;
    logic             rd_bad;
    logic [NBits-1:0] sel_rd;
    logic [NBits-1:0] chan_rd [NChan];
    logic [SUMW-1:0]  sums    [NChan];

    assign full   = cnt == DCNT;
    assign do_wr  = bus.wr_en && !bus.clear;
    assign rd_idx = wp - NAddr'(1) - bus.rd_offset;
    assign rd_bad = ({1'b0, bus.rd_offset} >= cnt)
                 || (int'(bus.rd_chan) >= NChan);

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wp  <= '0;
            cnt <= '0;
        end else if (bus.clear) begin
            wp  <= '0;
            cnt <= '0;
        end else if (bus.wr_en) begin
            wp  <= wp + NAddr'(1);
            if (!full) cnt <= cnt + 1'b1;
        end
    end

    genvar c;
    generate
        for (c = 0; c < NChan; c++) begin : g_chan
            logic signed [SUMW-1:0] s;

            ring_channel #(
                .NBits (NBits),
                .NAddr (NAddr)
            ) u_chan (
                .clk     (clk),
                .rst_a   (rst_a),
                .clear   (bus.clear),
                .wr_en   (do_wr),
                .full    (full),
                .wp      (wp),
                .rd_idx  (rd_idx),
                .sample  (`RSR_CH(bus.Data_in, c, NBits)),
                .rd_data (chan_rd[c]),
                .sum     (sums[c])
            );

            assign s = sums[c];
            assign `RSR_CH(bus.sum_out, c, SUMW) = sums[c];
            assign `RSR_CH(bus.avg_out, c, NBits) = NBits'(s >>> NAddr);
        end
    endgenerate

    always_comb begin
        sel_rd = '0;
        for (int i = 0; i < NChan; i++) begin
            if (int'(bus.rd_chan) == i) sel_rd = chan_rd[i];
        end
    end

    // Read sees pre-write, pre-clear state of this cycle
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            bus.Data_out <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
        end else if (bus.rd_req) begin
            bus.Data_out <= rd_bad ? '0 : sel_rd;
            bus.rd_valid <= 1'b1;
            bus.rd_err   <= rd_bad;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
        end
    end

    assign bus.count = cnt;
    assign bus.full  = full;

endmodule
